// File: rtl/goe_pkg.sv
// Shared definitions for the generic output engine transmit stage:
// packet word field positions, word-type codes and FSM state encoding.
package goe_pkg;

    localparam int WORD_W = 134;
    localparam int PHV_W  = 1024;
    localparam int PORT_W = 8;

    // Packet word layout
    localparam int TYPE_HI    = 133;
    localparam int TYPE_LO    = 132;
    localparam int IBC_HI     = 131;
    localparam int IBC_LO     = 128;
    localparam int PAYLOAD_HI = 127;
    localparam int PAYLOAD_LO = 0;

    // Word-type codes carried in [TYPE_HI:TYPE_LO]
    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] MID  = 2'b11;
    localparam logic [1:0] TAIL = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } goe_state_e;

    function automatic logic is_tail(input logic [WORD_W-1:0] word);
        return word[TYPE_HI:TYPE_LO] == TAIL;
    endfunction

endpackage

// File: rtl/goe_tx_if.sv
// Downstream packet bus of goe_tx: forwarded words, end-of-packet strobe,
// output port, and the almost-full flag returned by the consumer.
interface goe_tx_if;
    import goe_pkg::*;

    logic [WORD_W-1:0] out_goe_data;
    logic              out_goe_data_wr;
    logic              out_goe_valid_wr;
    logic              out_goe_valid;
    logic [PORT_W-1:0] out_goe_port;
    logic              in_goe_alf;

    modport master (
        output out_goe_data,
        output out_goe_data_wr,
        output out_goe_valid_wr,
        output out_goe_valid,
        output out_goe_port,
        input  in_goe_alf
    );

    modport slave (
        input  out_goe_data,
        input  out_goe_data_wr,
        input  out_goe_valid_wr,
        input  out_goe_valid,
        input  out_goe_port,
        output in_goe_alf
    );

endinterface

// File: rtl/goe_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is read
// combinationally from the storage array so it is visible in the same
// cycle it becomes valid. Writes when full and reads when empty are ignored.
module goe_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push;
    logic          pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    // Pointer and occupancy update; occupancy stays exact on push+pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers; reset flushes the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/goe_tx.sv
// Generic output engine transmit stage. Buffers complete packets from the
// packet-generation stage, then forwards each one word-by-word with its
// output port, or discards it when its per-packet valid flag is 0.
// Optional build macro GOE_STATS_EN: when defined, sent/dropped packet
// counters are implemented; otherwise both counter outputs are tied to 0.
module goe_tx
    import goe_pkg::*;
#(
    parameter int DATA_AW     = 9,
    parameter int META_AW     = 4,
    parameter int DATA_ALF_TH = 384,
    parameter int META_ALF_TH = 12,
    parameter int OPORT_LSB   = 1016
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_goe_data_wr,
    input  logic [WORD_W-1:0] in_goe_data,
    input  logic              in_goe_valid_wr,
    input  logic              in_goe_valid,
    output logic              out_goe_alf,
    input  logic [PHV_W-1:0]  in_goe_phv,
    input  logic              in_goe_phv_wr,
    output logic              out_goe_phv_alf,
    goe_tx_if.master          dn,
    output logic [31:0]       out_goe_pkt_cnt,
    output logic [31:0]       out_goe_drop_cnt,
    output logic              out_goe_ovf
);
    logic [WORD_W-1:0]  data_head;
    logic [DATA_AW:0]   data_cnt;
    logic               data_empty, data_full, data_pop;
    logic               flag_head, flag_empty, flag_full;
    logic [META_AW:0]   unused_flag_cnt;
    logic [PORT_W-1:0]  port_head;
    logic [META_AW:0]   port_cnt;
    logic               port_empty, port_full;
    logic               meta_pop;
    logic               unused_phv;

    goe_state_e         state_q, state_d;
    logic [PORT_W-1:0]  port_q, port_d;
    logic               dn_alf_q, dn_alf_d;
    logic               alf_q, alf_d;
    logic               phv_alf_q, phv_alf_d;
    logic               ovf_q, ovf_d;
    logic               tx_wr, tx_last;

    // Only the port field of the PHV is consumed
    assign unused_phv = ^in_goe_phv;

    goe_sync_fifo #(.W(WORD_W), .AW(DATA_AW)) u_data_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_goe_data_wr),
        .wr_data (in_goe_data),
        .rd_en   (data_pop),
        .rd_data (data_head),
        .count   (data_cnt),
        .empty   (data_empty),
        .full    (data_full)
    );

    goe_sync_fifo #(.W(1), .AW(META_AW)) u_flag_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_goe_valid_wr),
        .wr_data (in_goe_valid),
        .rd_en   (meta_pop),
        .rd_data (flag_head),
        .count   (unused_flag_cnt),
        .empty   (flag_empty),
        .full    (flag_full)
    );

    goe_sync_fifo #(.W(PORT_W), .AW(META_AW)) u_port_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_goe_phv_wr),
        .wr_data (in_goe_phv[OPORT_LSB +: PORT_W]),
        .rd_en   (meta_pop),
        .rd_data (port_head),
        .count   (port_cnt),
        .empty   (port_empty),
        .full    (port_full)
    );

`ifdef GOE_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
`endif

    // Packet scheduler: choose forward/discard per packet, then stream words
    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        meta_pop = 1'b0;
        data_pop = 1'b0;
        tx_wr    = 1'b0;
        tx_last  = 1'b0;
`ifdef GOE_STATS_EN
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!flag_empty && !port_empty) begin
                    if (flag_head) begin
                        // Downstream back-pressure only gates packet start
                        if (!dn_alf_q) begin
                            meta_pop = 1'b1;
                            port_d   = port_head;
                            state_d  = SEND;
                        end
                    end else begin
                        meta_pop = 1'b1;
                        state_d  = DROP;
                    end
                end
            end
            SEND: begin
                // An empty data FIFO here is an upstream fault: stall quietly
                if (!data_empty) begin
                    data_pop = 1'b1;
                    tx_wr    = 1'b1;
                    if (is_tail(data_head)) begin
                        tx_last = 1'b1;
                        state_d = IDLE;
`ifdef GOE_STATS_EN
                        pkt_cnt_d = pkt_cnt_q + 32'd1;
`endif
                    end
                end
            end
            DROP: begin
                if (!data_empty) begin
                    data_pop = 1'b1;
                    if (is_tail(data_head)) begin
                        state_d = IDLE;
`ifdef GOE_STATS_EN
                        drop_cnt_d = drop_cnt_q + 32'd1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flow-control flags and sticky overflow
    always_comb begin
        dn_alf_d  = dn.in_goe_alf;
        alf_d     = (data_cnt >= (DATA_AW+1)'(DATA_ALF_TH));
        phv_alf_d = (port_cnt >= (META_AW+1)'(META_ALF_TH));
        ovf_d     = ovf_q
                  | (in_goe_data_wr  & data_full)
                  | (in_goe_valid_wr & flag_full)
                  | (in_goe_phv_wr   & port_full);
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            port_q    <= '0;
            dn_alf_q  <= 1'b0;
            alf_q     <= 1'b0;
            phv_alf_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            dn_alf_q  <= dn_alf_d;
            alf_q     <= alf_d;
            phv_alf_q <= phv_alf_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef GOE_STATS_EN
    // Sent/dropped packet counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
    assign out_goe_pkt_cnt  = pkt_cnt_q;
    assign out_goe_drop_cnt = drop_cnt_q;
`else
    assign out_goe_pkt_cnt  = '0;
    assign out_goe_drop_cnt = '0;
`endif

    assign dn.out_goe_data     = tx_wr ? data_head : '0;
    assign dn.out_goe_data_wr  = tx_wr;
    assign dn.out_goe_valid_wr = tx_last;
    assign dn.out_goe_valid    = tx_last;
    assign dn.out_goe_port     = port_q;
    assign out_goe_alf         = alf_q;
    assign out_goe_phv_alf     = phv_alf_q;
    assign out_goe_ovf         = ovf_q;

endmodule

// File: tb/tb_goe_tx.sv
// Self-checking bench for goe_tx: directed scenarios plus randomized
// packet traffic compared against a packet-level reference model.
module tb_goe_tx;

`ifdef GOE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_MID  = 2'b11;
    localparam logic [1:0] T_TAIL = 2'b10;

    typedef struct {
        logic [133:0] data;
        logic [7:0]   port;
        logic         vwr;
        logic         v;
        int           cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_goe_data_wr = 1'b0;
    logic [133:0]  in_goe_data = '0;
    logic          in_goe_valid_wr = 1'b0;
    logic          in_goe_valid = 1'b0;
    logic          out_goe_alf;
    logic [1023:0] in_goe_phv = '0;
    logic          in_goe_phv_wr = 1'b0;
    logic          out_goe_phv_alf;
    logic [31:0]   out_goe_pkt_cnt;
    logic [31:0]   out_goe_drop_cnt;
    logic          out_goe_ovf;

    goe_tx_if dn_if ();

    goe_tx dut (
        .clk              (clk),
        .rst              (rst),
        .in_goe_data_wr   (in_goe_data_wr),
        .in_goe_data      (in_goe_data),
        .in_goe_valid_wr  (in_goe_valid_wr),
        .in_goe_valid     (in_goe_valid),
        .out_goe_alf      (out_goe_alf),
        .in_goe_phv       (in_goe_phv),
        .in_goe_phv_wr    (in_goe_phv_wr),
        .out_goe_phv_alf  (out_goe_phv_alf),
        .dn               (dn_if),
        .out_goe_pkt_cnt  (out_goe_pkt_cnt),
        .out_goe_drop_cnt (out_goe_drop_cnt),
        .out_goe_ovf      (out_goe_ovf)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    int    exp_pkts = 0;
    int    exp_drops = 0;
    int    stray_vwr = 0;
    beat_t obs_q[$];
    beat_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: one record per forwarded word
    always @(negedge clk) begin
        if (!rst && dn_if.out_goe_data_wr) begin
            beat_t b;
            b.data = dn_if.out_goe_data;
            b.port = dn_if.out_goe_port;
            b.vwr  = dn_if.out_goe_valid_wr;
            b.v    = dn_if.out_goe_valid;
            b.cyc  = cyc;
            obs_q.push_back(b);
            $display("beat %0d cyc=%0d data=%h port=%h vwr=%b", obs_q.size(), cyc, b.data, b.port, b.vwr);
        end else if (!rst && dn_if.out_goe_valid_wr) begin
            stray_vwr++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_cnt(input int n);
        return STATS_ON ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dwr, input logic [133:0] d, input logic pwr, input logic [7:0] port,
                         input logic vwr, input logic v, output int c);
        logic [1023:0] phv;
        for (int k = 0; k < 32; k++) phv[k*32 +: 32] = $urandom;
        if (pwr) phv[1016 +: 8] = port;
        in_goe_data_wr  = dwr;
        in_goe_data     = d;
        in_goe_phv_wr   = pwr;
        in_goe_phv      = phv;
        in_goe_valid_wr = vwr;
        in_goe_valid    = v;
        c = cyc;
        @(posedge clk);
        #1;
        in_goe_data_wr  = 1'b0;
        in_goe_phv_wr   = 1'b0;
        in_goe_valid_wr = 1'b0;
    endtask

    // Sends one packet; the reference model records what must appear downstream
    task automatic send_pkt(input int len, input logic v, input logic [7:0] port, input int vdelay,
                            output int strobe_cyc);
        int c;
        for (int i = 0; i < len; i++) begin
            logic [1:0]   t;
            logic [133:0] w;
            logic         last;
            last = (i == len - 1);
            t = (i == 0) ? T_HEAD : (last ? T_TAIL : T_MID);
            w = {t, 4'($urandom_range(0, 15)), rnd128()};
            if (v) exp_q.push_back('{data: w, port: port, vwr: last, v: last, cyc: 0});
            drive(1'b1, w, i == 0, port, last && (vdelay == 0), v, c);
            if (last) strobe_cyc = c;
        end
        if (vdelay > 0) begin
            if (vdelay > 1) idle(vdelay - 1);
            drive(1'b0, '0, 1'b0, 8'h00, 1'b1, v, strobe_cyc);
        end
        if (v) exp_pkts++;
        else exp_drops++;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dn_if.out_goe_data_wr, dn_if.out_goe_valid_wr, dn_if.out_goe_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes: got %b required 000", {dn_if.out_goe_data_wr, dn_if.out_goe_valid_wr, dn_if.out_goe_valid});
        end
        checks++;
        if ({out_goe_alf, out_goe_phv_alf, out_goe_ovf} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b required 000", {out_goe_alf, out_goe_phv_alf, out_goe_ovf});
        end
        checks++;
        if (dn_if.out_goe_data !== '0 || dn_if.out_goe_port !== 8'h00) begin
            failures++;
            $display("FAIL reset_data_port: got data=%h port=%h required 0", dn_if.out_goe_data, dn_if.out_goe_port);
        end
        checks++;
        if (out_goe_pkt_cnt !== 32'd0 || out_goe_drop_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters: got pkt=%0d drop=%0d required 0", out_goe_pkt_cnt, out_goe_drop_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_pkts = 0;
        exp_drops = 0;
        idle(2);
    endtask

    task automatic test_send();
        int sc;
        obs_q.delete();
        exp_q.delete();
        send_pkt(4, 1'b1, 8'h03, 0, sc);
        wait_beats(4, 50);
        idle(4);
        checks++;
        if (obs_q.size() != 4) begin
            failures++;
            $display("FAIL send_beats: got %0d required 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 4; i++) begin
            checks++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].port !== 8'h03 ||
                obs_q[i].vwr !== (i == 3) || obs_q[i].v !== (i == 3)) begin
                failures++;
                $display("FAIL send_beat%0d: got data=%h port=%h vwr=%b v=%b required data=%h port=03 vwr=%b",
                         i, obs_q[i].data, obs_q[i].port, obs_q[i].vwr, obs_q[i].v, exp_q[i].data, i == 3);
            end
        end
        if (obs_q.size() == 4) begin
            checks++;
            if (obs_q[0].cyc - sc != 2 || obs_q[3].cyc - obs_q[0].cyc != 3) begin
                failures++;
                $display("FAIL send_latency: got first=%0d span=%0d required first=2 span=3",
                         obs_q[0].cyc - sc, obs_q[3].cyc - obs_q[0].cyc);
            end
        end
        checks++;
        if (out_goe_pkt_cnt !== exp_cnt(exp_pkts)) begin
            failures++;
            $display("FAIL send_pkt_cnt: got %0d required %0d", out_goe_pkt_cnt, exp_cnt(exp_pkts));
        end
    endtask

    task automatic test_drop();
        int sc;
        obs_q.delete();
        exp_q.delete();
        send_pkt(4, 1'b0, 8'h03, 0, sc);
        idle(8);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL drop_no_beats: got %0d required 0", obs_q.size());
        end
        checks++;
        if (out_goe_drop_cnt !== exp_cnt(exp_drops) || out_goe_pkt_cnt !== exp_cnt(exp_pkts)) begin
            failures++;
            $display("FAIL drop_counters: got pkt=%0d drop=%0d required pkt=%0d drop=%0d",
                     out_goe_pkt_cnt, out_goe_drop_cnt, exp_cnt(exp_pkts), exp_cnt(exp_drops));
        end
        // A following forwarded packet proves the dropped words were fully consumed
        send_pkt(3, 1'b1, 8'h5a, 1, sc);
        wait_beats(3, 50);
        idle(4);
        checks++;
        if (obs_q.size() != 3) begin
            failures++;
            $display("FAIL drop_next_beats: got %0d required 3", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 3; i++) begin
            checks++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].port !== exp_q[i].port || obs_q[i].vwr !== exp_q[i].vwr) begin
                failures++;
                $display("FAIL drop_next_beat%0d: got %h/%h/%b required %h/%h/%b", i, obs_q[i].data, obs_q[i].port,
                         obs_q[i].vwr, exp_q[i].data, exp_q[i].port, exp_q[i].vwr);
            end
        end
    endtask

    task automatic test_alf_hold();
        int sc, c0;
        obs_q.delete();
        exp_q.delete();
        dn_if.in_goe_alf = 1'b1;
        send_pkt(4, 1'b1, 8'hc3, 0, sc);
        idle(10);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL alf_hold_no_output: got %0d beats required 0", obs_q.size());
        end
        c0 = cyc;
        dn_if.in_goe_alf = 1'b0;
        wait_beats(4, 50);
        idle(3);
        checks++;
        if (obs_q.size() != 4) begin
            failures++;
            $display("FAIL alf_hold_beats: got %0d required 4", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].cyc - c0 != 2) begin
                failures++;
                $display("FAIL alf_release_latency: got %0d required 2", obs_q[0].cyc - c0);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_q[i].data !== exp_q[i].data || obs_q[i].port !== 8'hc3) begin
                    failures++;
                    $display("FAIL alf_hold_beat%0d: got %h/%h required %h/c3", i, obs_q[i].data, obs_q[i].port, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic test_alf_midpacket();
        int sc;
        obs_q.delete();
        exp_q.delete();
        send_pkt(6, 1'b1, 8'(
            $urandom), 0, sc);
        wait_beats(2, 50);
        dn_if.in_goe_alf = 1'b1;
        wait_beats(6, 50);
        idle(3);
        checks++;
        if (obs_q.size() != 6) begin
            failures++;
            $display("FAIL alf_mid_beats: got %0d required 6", obs_q.size());
        end else begin
            checks++;
            if (obs_q[5].cyc - obs_q[0].cyc != 5) begin
                failures++;
                $display("FAIL alf_mid_contiguous: got span %0d required 5", obs_q[5].cyc - obs_q[0].cyc);
            end
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs_q[i].data !== exp_q[i].data || obs_q[i].port !== exp_q[i].port || obs_q[i].vwr !== exp_q[i].vwr) begin
                    failures++;
                    $display("FAIL alf_mid_beat%0d: got %h/%h/%b required %h/%h/%b", i, obs_q[i].data, obs_q[i].port,
                             obs_q[i].vwr, exp_q[i].data, exp_q[i].port, exp_q[i].vwr);
                end
            end
        end
        dn_if.in_goe_alf = 1'b0;
        idle(2);
    endtask

    task automatic test_rst_midpacket();
        int sc;
        obs_q.delete();
        exp_q.delete();
        send_pkt(6, 1'b1, 8'h77, 0, sc);
        wait_beats(3, 50);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({dn_if.out_goe_data_wr, dn_if.out_goe_valid_wr, dn_if.out_goe_valid, out_goe_alf, out_goe_phv_alf, out_goe_ovf} !== 6'b0
            || dn_if.out_goe_data !== '0 || dn_if.out_goe_port !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_outputs: got wr=%b vwr=%b data=%h port=%h required all 0",
                     dn_if.out_goe_data_wr, dn_if.out_goe_valid_wr, dn_if.out_goe_data, dn_if.out_goe_port);
        end
        checks++;
        if (out_goe_pkt_cnt !== 32'd0 || out_goe_drop_cnt !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_counters: got pkt=%0d drop=%0d required 0", out_goe_pkt_cnt, out_goe_drop_cnt);
        end
        #1;
        rst = 1'b0;
        exp_pkts = 0;
        exp_drops = 0;
        obs_q.delete();
        exp_q.delete();
        idle(3);
        send_pkt(5, 1'b1, 8'h21, 0, sc);
        wait_beats(5, 50);
        idle(4);
        checks++;
        if (obs_q.size() != 5) begin
            failures++;
            $display("FAIL rst_mid_next_beats: got %0d required 5", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 5; i++) begin
            checks++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].port !== 8'h21 || obs_q[i].vwr !== exp_q[i].vwr) begin
                failures++;
                $display("FAIL rst_mid_next_beat%0d: got %h/%h/%b required %h/21/%b", i, obs_q[i].data, obs_q[i].port,
                         obs_q[i].vwr, exp_q[i].data, exp_q[i].vwr);
            end
        end
        checks++;
        if (out_goe_pkt_cnt !== exp_cnt(1) || out_goe_drop_cnt !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_restart_cnt: got pkt=%0d drop=%0d required pkt=%0d drop=0",
                     out_goe_pkt_cnt, out_goe_drop_cnt, exp_cnt(1));
        end
    endtask

    task automatic test_fill_ovf();
        int c;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 384; i++) drive(1'b1, {T_MID, 4'h0, rnd128()}, 1'b0, 8'h00, 1'b0, 1'b0, c);
        checks++;
        if (out_goe_alf !== 1'b0) begin
            failures++;
            $display("FAIL alf_lag: got %b required 0 on the cycle occupancy reaches 384", out_goe_alf);
        end
        idle(1);
        checks++;
        if (out_goe_alf !== 1'b1) begin
            failures++;
            $display("FAIL alf_assert: got %b required 1", out_goe_alf);
        end
        for (int i = 384; i < 512; i++) drive(1'b1, {T_MID, 4'h0, rnd128()}, 1'b0, 8'h00, 1'b0, 1'b0, c);
        checks++;
        if (out_goe_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_at_full: got %b required 0 after 512 writes", out_goe_ovf);
        end
        drive(1'b1, {T_MID, 4'h0, rnd128()}, 1'b0, 8'h00, 1'b0, 1'b0, c);
        checks++;
        if (out_goe_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: got %b required 1 after 513 writes", out_goe_ovf);
        end
        idle(5);
        checks++;
        if (out_goe_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: got %b required 1", out_goe_ovf);
        end
        for (int i = 0; i < 12; i++) drive(1'b0, '0, 1'b1, 8'(i), 1'b0, 1'b0, c);
        checks++;
        if (out_goe_phv_alf !== 1'b0) begin
            failures++;
            $display("FAIL phv_alf_lag: got %b required 0", out_goe_phv_alf);
        end
        idle(1);
        checks++;
        if (out_goe_phv_alf !== 1'b1 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL phv_alf_assert: got alf=%b beats=%0d required alf=1 beats=0", out_goe_phv_alf, obs_q.size());
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_pkts = 0;
        exp_drops = 0;
        checks++;
        if ({out_goe_ovf, out_goe_alf, out_goe_phv_alf} !== 3'b000) begin
            failures++;
            $display("FAIL fill_reset_flags: got %b required 000", {out_goe_ovf, out_goe_alf, out_goe_phv_alf});
        end
        idle(2);
    endtask

    task automatic test_random();
        int sc;
        obs_q.delete();
        exp_q.delete();
        stray_vwr = 0;
        for (int p = 0; p < 40; p++) begin
            int k = 0;
            while ((out_goe_alf || out_goe_phv_alf) && k < 200) begin
                idle(1);
                k++;
            end
            dn_if.in_goe_alf = ($urandom_range(0, 3) == 0);
            send_pkt($urandom_range(2, 8), $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2), sc);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        dn_if.in_goe_alf = 1'b0;
        wait_beats(exp_q.size(), 3000);
        idle(6);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_beats: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].port !== exp_q[i].port ||
                obs_q[i].vwr !== exp_q[i].vwr || obs_q[i].v !== exp_q[i].v) begin
                failures++;
                $display("FAIL rand_beat%0d: got %h/%h/%b/%b required %h/%h/%b/%b", i, obs_q[i].data, obs_q[i].port,
                         obs_q[i].vwr, obs_q[i].v, exp_q[i].data, exp_q[i].port, exp_q[i].vwr, exp_q[i].v);
            end
        end
        checks++;
        if (out_goe_pkt_cnt !== exp_cnt(exp_pkts) || out_goe_drop_cnt !== exp_cnt(exp_drops)) begin
            failures++;
            $display("FAIL rand_counters: got pkt=%0d drop=%0d required pkt=%0d drop=%0d",
                     out_goe_pkt_cnt, out_goe_drop_cnt, exp_cnt(exp_pkts), exp_cnt(exp_drops));
        end
        checks++;
        if (stray_vwr != 0 || out_goe_ovf !== 1'b0) begin
            failures++;
            $display("FAIL rand_misc: got stray_vwr=%0d ovf=%b required 0/0", stray_vwr, out_goe_ovf);
        end
    endtask

    initial begin
        dn_if.in_goe_alf = 1'b0;
        test_reset();
        test_send();
        test_drop();
        test_alf_hold();
        test_alf_midpacket();
        test_rst_midpacket();
        test_fill_ovf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/goe_tx.md
Name: goe_tx

Overview:
- Generic output engine stage directly downstream of the packet-generation stage (pgm).
- Consumes pgm's 134-bit packet words, per-packet valid flags and 1024-bit PHVs.
- Buffers each complete packet (store-and-forward), then forwards it word-by-word with its output port, or silently discards it when the valid flag is 0.
- Sends almost-full back-pressure upstream and keeps sent/dropped packet counters.

Parameters:
- DATA_AW, 9, data FIFO address width (depth 512 words).
- META_AW, 4, valid-flag and port FIFO address width (depth 16 entries each).
- DATA_ALF_TH, 384, data FIFO occupancy at or above which out_goe_alf asserts.
- META_ALF_TH, 12, port FIFO occupancy at or above which out_goe_phv_alf asserts.
- OPORT_LSB, 1016, LSB of the 8-bit output-port field in the PHV.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_goe_data_wr  in  1  data word strobe.
- in_goe_data  in  134  packet word: [133:132] 01=head, 11=middle, 10=tail; [131:128] invalid byte count; [127:0] payload.
- in_goe_valid_wr  in  1  per-packet flag strobe, coincident with or after the tail word.
- in_goe_valid  in  1  1=forward, 0=discard.
- out_goe_alf  out  1  data almost-full.
- in_goe_phv  in  1024  packet header vector.
- in_goe_phv_wr  in  1  PHV strobe (one per packet).
- out_goe_phv_alf  out  1  port FIFO almost-full.
- out_goe_data  out  134  forwarded word.
- out_goe_data_wr  out  1  forwarded word strobe.
- out_goe_valid_wr  out  1  packet-end strobe.
- out_goe_valid  out  1  always 1 when out_goe_valid_wr=1.
- out_goe_port  out  8  output port; held for the whole packet.
- in_goe_alf  in  1  downstream almost-full.
- out_goe_pkt_cnt  out  32  packets forwarded.
- out_goe_drop_cnt  out  32  packets discarded.
- out_goe_ovf  out  1  sticky overflow flag.

Behaviour:
- Reset:
  - All outputs 0.
  - FIFOs flushed, FSM to IDLE, counters 0, out_goe_ovf cleared.
  - Reset mid-packet abandons the packet with no tail emitted.
- FIFO writes:
  - Data FIFO pushes in_goe_data on in_goe_data_wr.
  - Flag FIFO pushes in_goe_valid on in_goe_valid_wr.
  - Port FIFO pushes in_goe_phv[OPORT_LSB+:8] on in_goe_phv_wr.
- Overflow: a write to a full FIFO is dropped and sets out_goe_ovf, which stays set until rst.
- Almost-full: out_goe_alf and out_goe_phv_alf are registered compares on occupancy (one-cycle lag). Occupancy is exact on simultaneous push and pop.
- FSM states IDLE, SEND, DROP:
  - IDLE -> SEND when flag FIFO non-empty, port FIFO non-empty, flag=1 and in_goe_alf=0. Pop the flag and port entries and latch the port.
  - IDLE -> DROP when both FIFOs non-empty and flag=0. Pop both entries; in_goe_alf is ignored.
  - IDLE holds otherwise.
  - SEND: pop one data word per cycle and drive it on out_goe_data with out_goe_data_wr=1. in_goe_alf is not re-sampled mid-packet. On the tail word, also drive out_goe_valid_wr=1, out_goe_valid=1, increment out_goe_pkt_cnt, and return to IDLE.
  - DROP: pop one word per cycle with no output. On the tail, increment out_goe_drop_cnt and return to IDLE.
- Throughput and latency:
  - One IDLE bubble between packets.
  - Latency from the valid strobe (with data already buffered) to the first output word is 2 cycles.
- Data FIFO empty while in SEND/DROP is an upstream error: stall without popping and keep out_goe_data_wr low.
- Counters wrap at 2^32.

Optional Feature:
- Macro GOE_STATS_EN.
  - Defined: out_goe_pkt_cnt and out_goe_drop_cnt count as described above.
  - Undefined: counter registers are removed and both outputs are tied to 0.
- Forwarding behaviour is identical in both builds.

Decomposition:
- Shared package goe_pkg:
  - word-type constants: HEAD=2'b01, MID=2'b11, TAIL=2'b10.
  - FSM state encoding: IDLE=0, SEND=1, DROP=2.
  - word-field bit positions.
- Sub-module goe_sync_fifo:
  - first-word-fall-through, parameterised width and address width.
  - outputs: count, empty, full.
  - instantiated three times: 134-bit data FIFO, 1-bit flag FIFO, 8-bit port FIFO.

Test Plan:
- 4-word packet (head, mid, mid, tail) with valid=1 and PHV port=8'h03 -> four out_goe_data_wr beats with out_goe_port=3. out_goe_valid_wr is on beat 4 only; pkt_cnt=1.
- Same packet with valid=0 -> no out_goe_data_wr beats; drop_cnt=1, pkt_cnt unchanged.
- in_goe_alf=1 while a packet is buffered -> no output. Deassert -> output starts 2 cycles later.
- in_goe_alf asserted on beat 2 of 6 -> all 6 beats still emitted back-to-back.
- Push 384 words without draining -> out_goe_alf=1 one cycle after occupancy reaches 384. Push 513 words -> out_goe_ovf=1 and stays set.
- rst pulsed during beat 3 of a SEND -> all outputs 0 next cycle. A following new packet is forwarded intact with counters restarted at 0.
